// File: rtl/vaccine_pkg.sv
// Shared types and initial vaccine layout for the wave scheduler.
package vaccine_pkg;

  localparam int NUM_SLOTS = 10;

  typedef logic signed [10:0] coord_t;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GEN    = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  localparam coord_t INIT_X [NUM_SLOTS] = '{
    11'sd70, 11'sd80, 11'sd140, 11'sd200, 11'sd170,
    11'sd330, 11'sd370, 11'sd480, 11'sd440, 11'sd550
  };

  localparam coord_t INIT_Y [NUM_SLOTS] = '{
    11'sd200, 11'sd320, 11'sd160, 11'sd200, 11'sd410,
    11'sd330, 11'sd170, 11'sd380, 11'sd180, 11'sd180
  };

  // Bit 0 corresponds to slot 0.
  localparam logic [NUM_SLOTS-1:0] INIT_MASK = 10'h3da;

endpackage

// File: rtl/vaccine_wave_scheduler_if.sv
// Bus between the collision/random logic, the scheduler and the drawers.
interface vaccine_wave_scheduler_if #(
  parameter int NUM_SLOTS = 10
);
  import vaccine_pkg::*;

  logic                 startOfFrame;
  logic                 collision;
  logic [3:0]           collision_slot;
  logic                 in_circular;
  logic [10:0]          randX;
  logic [10:0]          randY;
  logic [NUM_SLOTS-1:0] rand_mask;
  coord_t               topLeftX [NUM_SLOTS];
  coord_t               topLeftY [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] draw_request;
  logic                 wave_load;
  logic [7:0]           wave_count;
  logic                 busy;

  modport master (
    output startOfFrame, collision, collision_slot, in_circular,
           randX, randY, rand_mask,
    input  topLeftX, topLeftY, draw_request, wave_load, wave_count, busy
  );

  modport slave (
    input  startOfFrame, collision, collision_slot, in_circular,
           randX, randY, rand_mask,
    output topLeftX, topLeftY, draw_request, wave_load, wave_count, busy
  );

endinterface

// File: rtl/vaccine_pos_sampler.sv
// Combinational legality check and per-axis clamp of one random position.
module vaccine_pos_sampler
  import vaccine_pkg::*;
#(
  parameter int X_MIN = 32,
  parameter int X_MAX = 575,
  parameter int Y_MIN = 96,
  parameter int Y_MAX = 415
) (
  input  logic [10:0] sample_x,
  input  logic [10:0] sample_y,
  output logic        in_range,
  output coord_t      clamp_x,
  output coord_t      clamp_y
);

  localparam logic [10:0] XL = 11'(X_MIN);
  localparam logic [10:0] XH = 11'(X_MAX);
  localparam logic [10:0] YL = 11'(Y_MIN);
  localparam logic [10:0] YH = 11'(Y_MAX);

  // Unsigned inclusive bounds check; clamped value equals the sample when legal.
  always_comb begin
    in_range = (sample_x >= XL) && (sample_x <= XH) &&
               (sample_y >= YL) && (sample_y <= YH);
    clamp_x = coord_t'(sample_x);
    if (sample_x < XL)      clamp_x = coord_t'(XL);
    else if (sample_x > XH) clamp_x = coord_t'(XH);
    clamp_y = coord_t'(sample_y);
    if (sample_y < YL)      clamp_y = coord_t'(YL);
    else if (sample_y > YH) clamp_y = coord_t'(YH);
  end

endmodule

// File: rtl/vaccine_wave_scheduler.sv
// Vaccine slot table owner: clears hit slots, then builds and atomically
// commits a new wave once the field is empty and the clamp has settled.
module vaccine_wave_scheduler #(
  parameter int NUM_SLOTS     = 10,
  parameter int X_MIN         = 32,
  parameter int X_MAX         = 575,
  parameter int Y_MIN         = 96,
  parameter int Y_MAX         = 415,
  parameter int MIN_ALIVE     = 3,
  parameter int SETTLE_FRAMES = 30,
  parameter int MAX_RETRY     = 15
) (
  input logic clk,
  input logic resetN,
  vaccine_wave_scheduler_if.slave bus
);
  import vaccine_pkg::*;

  localparam logic [1:0] ACTIVE = ST_ACTIVE;
  localparam logic [1:0] SETTLE = ST_SETTLE;
  localparam logic [1:0] GEN    = ST_GEN;
  localparam logic [1:0] COMMIT = ST_COMMIT;

  localparam int FW = $clog2(SETTLE_FRAMES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [FW-1:0] FRAME_LIM = FW'(SETTLE_FRAMES);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [3:0]    LAST_SLOT = 4'(NUM_SLOTS - 1);

  logic [1:0]           state;
  logic [FW-1:0]        frame_cnt;
  logic [RW-1:0]        retry;
  logic [3:0]           slot_idx;
  logic [NUM_SLOTS-1:0] wave_mask;
  logic [NUM_SLOTS-1:0] draw_q;
  coord_t               shadow_x [NUM_SLOTS];
  coord_t               shadow_y [NUM_SLOTS];
  coord_t               x_q [NUM_SLOTS];
  coord_t               y_q [NUM_SLOTS];
  logic                 load_q;
  logic [7:0]           count_q;
  logic                 busy_q;

  logic   in_range;
  coord_t clamp_x;
  coord_t clamp_y;

  vaccine_pos_sampler #(
    .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)
  ) u_sampler (
    .sample_x (bus.randX),
    .sample_y (bus.randY),
    .in_range (in_range),
    .clamp_x  (clamp_x),
    .clamp_y  (clamp_y)
  );

  // Slot-table FSM: clear on hit, settle, generate into shadow, commit at once.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= ACTIVE;
      frame_cnt <= '0;
      retry     <= '0;
      slot_idx  <= '0;
      wave_mask <= '0;
      draw_q    <= INIT_MASK;
      load_q    <= 1'b0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow_x[i] <= '0;
        shadow_y[i] <= '0;
        x_q[i]      <= INIT_X[i];
        y_q[i]      <= INIT_Y[i];
      end
    end else begin
      load_q <= 1'b0;
      case (state)
        ACTIVE: begin
          if (draw_q == '0) begin
            state     <= SETTLE;
            frame_cnt <= '0;
            busy_q    <= 1'b1;
          end else if (bus.collision && (int'(bus.collision_slot) < NUM_SLOTS)) begin
            draw_q[bus.collision_slot] <= 1'b0;
          end
        end
        SETTLE: begin
          if (bus.startOfFrame && (frame_cnt != FRAME_LIM))
            frame_cnt <= frame_cnt + 1'b1;
          if ((frame_cnt == FRAME_LIM) && bus.in_circular) begin
            state     <= GEN;
            wave_mask <= ($countones(bus.rand_mask) < MIN_ALIVE) ? '1 : bus.rand_mask;
            slot_idx  <= '0;
            retry     <= '0;
          end
        end
        GEN: begin
          // A legal sample, or the last permitted retry, fills the slot.
          if (in_range || (retry == RETRY_LIM)) begin
            shadow_x[slot_idx] <= clamp_x;
            shadow_y[slot_idx] <= clamp_y;
            retry <= '0;
            if (slot_idx == LAST_SLOT) state <= COMMIT;
            else                       slot_idx <= slot_idx + 1'b1;
          end else begin
            retry <= retry + 1'b1;
          end
        end
        default: begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            x_q[i] <= shadow_x[i];
            y_q[i] <= shadow_y[i];
          end
          draw_q <= wave_mask;
          load_q <= 1'b1;
          if (count_q != 8'hff) count_q <= count_q + 1'b1;
          state  <= ACTIVE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.topLeftX     = x_q;
  assign bus.topLeftY     = y_q;
  assign bus.draw_request = draw_q;
  assign bus.wave_load    = load_q;
  assign bus.wave_count   = count_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vaccine_wave_scheduler.sv
// Randomized and directed bench for vaccine_wave_scheduler with a behavioural model.
module tb_vaccine_wave_scheduler;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  vaccine_wave_scheduler_if #(.NUM_SLOTS(10)) bus ();

  vaccine_wave_scheduler dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  const int INX [10] = '{70, 80, 140, 200, 170, 330, 370, 480, 440, 550};
  const int INY [10] = '{200, 320, 160, 200, 410, 330, 170, 380, 180, 180};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ph, m_frames, m_draw, m_mask, m_count;
  bit m_load, m_busy;
  int m_x [10], m_y [10], sh_x [10], sh_y [10];
  int qx [$], qy [$];

  function automatic int clampv(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Replays every GEN sample so far; returns how many slots are decided.
  function automatic int walk();
    int slot = 0;
    int tries = 0;
    foreach (qx[k]) begin
      bit ok;
      ok = (qx[k] >= 32) && (qx[k] <= 575) && (qy[k] >= 96) && (qy[k] <= 415);
      if (slot < 10) begin
        if (ok || tries == 15) begin
          sh_x[slot] = clampv(qx[k], 32, 575);
          sh_y[slot] = clampv(qy[k], 96, 415);
          slot++;
          tries = 0;
        end else begin
          tries++;
        end
      end
    end
    return slot;
  endfunction

  always @(posedge clk) begin
    if (!resetN) begin
      m_ph = 0; m_frames = 0; m_draw = 'h3da; m_mask = 0; m_count = 0;
      m_load = 0; m_busy = 0; m_x = INX; m_y = INY;
      qx.delete(); qy.delete();
    end else begin
      m_load = 0;
      case (m_ph)
        0: begin
          if (m_draw == 0) begin
            m_ph = 1; m_frames = 0; m_busy = 1;
          end else if (bus.collision && int'(bus.collision_slot) < 10) begin
            m_draw = m_draw & ~(1 << int'(bus.collision_slot));
          end
        end
        1: begin
          if (m_frames == 30 && bus.in_circular) begin
            m_ph = 2;
            m_mask = ($countones(bus.rand_mask) < 3) ? 'h3ff : int'(bus.rand_mask);
            qx.delete(); qy.delete();
          end else if (bus.startOfFrame && m_frames < 30) begin
            m_frames++;
          end
        end
        2: begin
          qx.push_back(int'(bus.randX));
          qy.push_back(int'(bus.randY));
          if (walk() == 10) m_ph = 3;
        end
        default: begin
          m_x = sh_x; m_y = sh_y; m_draw = m_mask; m_load = 1;
          if (m_count < 255) m_count++;
          m_ph = 0; m_busy = 0;
        end
      endcase
    end
  end

  // Every-cycle comparison of all registered outputs against the model.
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("draw_request", 32'(bus.draw_request), m_draw);
      chk("wave_load", 32'(bus.wave_load), 32'(m_load));
      chk("wave_count", 32'(bus.wave_count), m_count);
      chk("busy", 32'(bus.busy), 32'(m_busy));
      for (int i = 0; i < 10; i++) begin
        chk("topLeftX", 32'(bus.topLeftX[i]), m_x[i]);
        chk("topLeftY", 32'(bus.topLeftY[i]), m_y[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.startOfFrame = 0; bus.collision = 0; bus.collision_slot = 0;
    bus.in_circular = 1; bus.randX = 11'd100; bus.randY = 11'd200;
    bus.rand_mask = 10'h3ff;
  endtask

  task automatic clear_all();
    for (int s = 0; s < 10; s++) begin
      bus.collision = 1; bus.collision_slot = 4'(s); step();
    end
    bus.collision = 0;
    step(); step();
  endtask

  task automatic settle(input int n, input bit circ);
    for (int i = 0; i < n; i++) begin
      bus.startOfFrame = 1; bus.in_circular = circ; step();
    end
    bus.startOfFrame = 0;
    step();
  endtask

  task automatic wait_load(input int bound);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      step();
      if (bus.wave_load) seen = 1;
    end
    chk("wave_load_seen", 32'(seen), 1);
  endtask

  task automatic run_gen(input int nx, input int fx, input int rx);
    bus.randY = 11'd200;
    for (int i = 0; i < nx; i++) begin
      bus.randX = 11'(fx); step();
    end
    bus.randX = 11'(rx);
    wait_load(300);
  endtask

  task automatic rand_wave();
    bit seen = 0;
    for (int i = 0; i < 15; i++) begin
      bus.collision = 1'($urandom_range(0, 1));
      bus.collision_slot = 4'($urandom_range(0, 15));
      step();
    end
    clear_all();
    for (int i = 0; i < 3000 && !seen; i++) begin
      bus.startOfFrame = ($urandom_range(0, 1) == 1);
      bus.in_circular = ($urandom_range(0, 3) != 0);
      bus.collision = 1'($urandom_range(0, 1));
      bus.collision_slot = 4'($urandom_range(0, 15));
      bus.randX = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(32, 575)) : 11'($urandom_range(0, 2047));
      bus.randY = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(96, 415)) : 11'($urandom_range(0, 2047));
      bus.rand_mask = 10'($urandom);
      step();
      if (bus.wave_load) seen = 1;
    end
    chk("rand_wave_load", 32'(seen), 1);
    idle_inputs();
  endtask

  initial begin
    resetN = 0;
    idle_inputs();
    repeat (3) step();
    resetN = 1;
    cmp_en = 1;
    chk("rst_draw", 32'(bus.draw_request), 32'h3da);
    chk("rst_x0", 32'(bus.topLeftX[0]), 70);
    chk("rst_y4", 32'(bus.topLeftY[4]), 410);
    chk("rst_count", 32'(bus.wave_count), 0);
    chk("rst_busy", 32'(bus.busy), 0);

    // First wave with constant legal samples.
    clear_all();
    settle(28, 1'b1);
    chk("settle_busy", 32'(bus.busy), 1);
    chk("settle_no_load", 32'(bus.wave_load), 0);
    bus.rand_mask = 10'h155;
    settle(2, 1'b1);
    run_gen(0, 0, 100);
    chk("w1_draw", 32'(bus.draw_request), 32'h155);
    for (int i = 0; i < 10; i++) chk("w1_x", 32'(bus.topLeftX[i]), 100);
    chk("w1_count", 32'(bus.wave_count), 1);

    // Out-of-range index and a hit on an already-cleared slot.
    step();
    bus.collision = 1; bus.collision_slot = 4'd12; step();
    bus.collision_slot = 4'd1; step();
    bus.collision = 0; step();
    chk("bad_idx_draw", 32'(bus.draw_request), 32'h155);

    // Three rejected X samples before a legal one.
    clear_all();
    settle(30, 1'b1);
    run_gen(3, 700, 300);
    chk("retry_x0", 32'(bus.topLeftX[0]), 300);

    // Sixteen low samples force a clamp to X_MIN.
    clear_all();
    settle(30, 1'b1);
    run_gen(16, 5, 100);
    chk("clamp_x0", 32'(bus.topLeftX[0]), 32);
    chk("clamp_x1", 32'(bus.topLeftX[1]), 100);

    // Sparse mask promoted to all slots.
    bus.rand_mask = 10'h003;
    clear_all();
    settle(30, 1'b1);
    run_gen(0, 0, 200);
    chk("sparse_draw", 32'(bus.draw_request), 32'h3ff);
    chk("sparse_count", 32'(bus.wave_count), 4);

    // Clamp not circular: hold in SETTLE until it is.
    bus.rand_mask = 10'h2aa;
    clear_all();
    settle(30, 1'b0);
    repeat (10) step();
    chk("hold_busy", 32'(bus.busy), 1);
    chk("hold_draw", 32'(bus.draw_request), 0);
    bus.in_circular = 1;
    run_gen(0, 0, 400);
    chk("hold_draw_after", 32'(bus.draw_request), 32'h2aa);

    repeat (5) rand_wave();

    // Reset in the middle of generation.
    clear_all();
    settle(30, 1'b1);
    bus.randX = 11'd2000;
    repeat (4) step();
    resetN = 0;
    step(); step();
    resetN = 1;
    step();
    chk("midgen_draw", 32'(bus.draw_request), 32'h3da);
    chk("midgen_busy", 32'(bus.busy), 0);
    chk("midgen_x0", 32'(bus.topLeftX[0]), 70);
    chk("midgen_count", 32'(bus.wave_count), 0);
    idle_inputs();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
